mem_stage_lsu: RTL and testbench

Memory-stage load/store unit of the pipelined core. Takes the execute-stage ALU result (address) and forwarded store data, runs a single outstanding request/acknowledge transaction on the data-memory bus, and returns sign/zero-extended load data. Stalls the pipeline while a transaction is in flight and supplies the memory-to-execute forward line.

---
 rtl/mem_stage_lsu.sv | 130 +++++++++++++
 tb/tb_mem_stage_lsu.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one outstanding req/ack bus transaction,
// lane steering for stores, sign/zero extension for loads, pipeline stall.
module mem_stage_lsu (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_memory_data,
  output logic [31:0] o_m_e_forward_data,
  output logic        o_stall,
  output logic [31:0] o_load_data,
  output logic        o_load_valid,
  output logic        o_misaligned,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_be,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q, load_data_q;
  logic [3:0]  bus_be_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;

  logic        access, is_byte, is_half, misaligned, accept;
  logic [31:0] wdata_d, lane, ext;
  logic [3:0]  be_d;

  // Access decode, alignment check and store lane steering.
  always_comb begin
    access  = i_valid & (i_mem_read | i_mem_write);
    // funct3[1:0] selects size; unlisted encodings fall through to word.
    is_byte = (i_funct3[1:0] == 2'b00);
    is_half = (i_funct3[1:0] == 2'b01);
    if (is_half) begin
      misaligned = i_alu_result[0];
    end else begin
      misaligned = !is_byte && (i_alu_result[1:0] != 2'b00);
    end
    accept  = (state_q == StIdle) && access && !misaligned;
    wdata_d = '0;
    be_d    = 4'b1111;
    if (i_mem_write) begin
      if (is_byte) begin
        wdata_d = {4{i_memory_data[7:0]}};
        be_d    = 4'b0001 << i_alu_result[1:0];
      end else if (is_half) begin
        wdata_d = {2{i_memory_data[15:0]}};
        be_d    = i_alu_result[1] ? 4'b1100 : 4'b0011;
      end else begin
        wdata_d = i_memory_data;
      end
    end
  end

  // Load lane extraction and extension from the returned word.
  always_comb begin
    lane = i_bus_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ext = {24'b0, lane[7:0]};
      3'b101:  ext = {16'b0, lane[15:0]};
      default: ext = lane;
    endcase
  end

  // Transaction FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StWait;
      StWait:  if (i_bus_ack) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, bus request fields and captured load data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      funct3_q    <= '0;
      lane_q      <= '0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        bus_we_q    <= i_mem_write;
        bus_addr_q  <= {i_alu_result[31:2], 2'b00};
        bus_wdata_q <= wdata_d;
        bus_be_q    <= be_d;
        funct3_q    <= i_funct3;
        lane_q      <= i_alu_result[1:0];
      end
      if ((state_q == StWait) && i_bus_ack && !bus_we_q) begin
        load_data_q <= ext;
      end
    end
  end

  // Outputs; reset gates the combinational stall/misaligned paths.
  always_comb begin
    o_m_e_forward_data = i_alu_result;
    o_bus_req          = (state_q == StWait);
    o_bus_we           = bus_we_q;
    o_bus_addr         = bus_addr_q;
    o_bus_wdata        = bus_wdata_q;
    o_bus_be           = bus_be_q;
    o_load_data        = load_data_q;
    o_load_valid       = (state_q == StDone) && !bus_we_q;
    o_stall            = !i_rst && (accept || (state_q == StWait));
    o_misaligned       = !i_rst && (state_q == StIdle) && access && misaligned;
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: driver pushes expected bus requests and
// load results; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_stage_lsu;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  localparam logic [2:0] F3B = 3'b000, F3H = 3'b001, F3W = 3'b010, F3BU = 3'b100, F3HU = 3'b101;

  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        i_valid = 1'b0, i_mem_read = 1'b0, i_mem_write = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_alu_result = '0, i_memory_data = '0, i_bus_rdata = '0;
  logic        i_bus_ack = 1'b0;
  logic [31:0] o_m_e_forward_data, o_load_data, o_bus_addr, o_bus_wdata;
  logic        o_stall, o_load_valid, o_misaligned, o_bus_req, o_bus_we;
  logic [3:0]  o_bus_be;

  int n_checks = 0;
  int n_fail   = 0;
  bus_t        bus_q[$];
  logic [31:0] load_q[$];

  mem_stage_lsu dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_valid            (i_valid),
    .i_mem_read         (i_mem_read),
    .i_mem_write        (i_mem_write),
    .i_funct3           (i_funct3),
    .i_alu_result       (i_alu_result),
    .i_memory_data      (i_memory_data),
    .o_m_e_forward_data (o_m_e_forward_data),
    .o_stall            (o_stall),
    .o_load_data        (o_load_data),
    .o_load_valid       (o_load_valid),
    .o_misaligned       (o_misaligned),
    .o_bus_req          (o_bus_req),
    .o_bus_we           (o_bus_we),
    .o_bus_addr         (o_bus_addr),
    .o_bus_wdata        (o_bus_wdata),
    .o_bus_be           (o_bus_be),
    .i_bus_ack          (i_bus_ack),
    .i_bus_rdata        (i_bus_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_funct3 = '0; i_alu_result = '0; i_memory_data = '0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data);
    i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr;
    i_funct3 = f3; i_alu_result = addr; i_memory_data = data;
  endtask

  // One aligned access; called just after a posedge with the DUT in IDLE.
  task automatic mem_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data, input int lat,
                        input logic [31:0] rdata, input bus_t eb, input logic load_en,
                        input logic [31:0] eload);
    bus_q.push_back(eb);
    if (load_en) load_q.push_back(eload);
    drive(rd, wr, f3, addr, data);
    @(negedge i_clk);
    check("stall_accept", {31'b0, o_stall}, 32'd1);
    check("forward_data", o_m_e_forward_data, addr);
    for (int c = 1; c <= lat; c++) begin
      @(posedge i_clk); #1;
      if (c == lat) begin
        i_bus_ack = 1'b1; i_bus_rdata = rdata;
      end
      @(negedge i_clk);
      check("stall_wait", {31'b0, o_stall}, 32'd1);
    end
    @(posedge i_clk); #1;
    i_bus_ack = 1'b0; i_bus_rdata = '0;
    @(negedge i_clk);
    check("stall_done", {31'b0, o_stall}, 32'd0);
    check("req_done", {31'b0, o_bus_req}, 32'd0);
    @(posedge i_clk); #1;
    idle_inputs();
  endtask

  task automatic misaligned_op(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr);
    drive(rd, wr, f3, addr, 32'h1234_5678);
    @(negedge i_clk);
    check("misaligned_flag", {31'b0, o_misaligned}, 32'd1);
    check("misaligned_stall", {31'b0, o_stall}, 32'd0);
    @(posedge i_clk); #1;
    idle_inputs();
    @(negedge i_clk);
    check("misaligned_clear", {31'b0, o_misaligned}, 32'd0);
    @(posedge i_clk); #1;
  endtask

  // Monitor: bus request fields on every request cycle, load results when valid.
  initial begin
    bus_t cur;
    logic prev_req, have_cur;
    prev_req = 1'b0; have_cur = 1'b0; cur = '0;
    forever begin
      @(negedge i_clk);
      if (o_bus_req) begin
        if (!prev_req) begin
          if (bus_q.size() == 0) begin
            n_checks++; n_fail++; have_cur = 1'b0;
            $display("FAIL unexpected_req: got addr 0x%08h expected no request", o_bus_addr);
          end else begin
            cur = bus_q.pop_front(); have_cur = 1'b1;
          end
        end
        if (have_cur) begin
          check("bus_addr", o_bus_addr, cur.addr);
          check("bus_we", {31'b0, o_bus_we}, {31'b0, cur.we});
          check("bus_wdata", o_bus_wdata, cur.wdata);
          check("bus_be", {28'b0, o_bus_be}, {28'b0, cur.be});
        end
      end
      prev_req = o_bus_req;
      if (o_load_valid) begin
        if (load_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_load_valid: got data 0x%08h expected no load", o_load_data);
        end else begin
          check("load_data", o_load_data, load_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a misaligned then an aligned access presented.
    drive(1'b1, 1'b0, F3W, 32'h102, 32'h0);
    @(negedge i_clk);
    check("rst_misaligned", {31'b0, o_misaligned}, 32'd0);
    check("rst_stall_mis", {31'b0, o_stall}, 32'd0);
    drive(1'b1, 1'b0, F3W, 32'h100, 32'h0);
    @(negedge i_clk);
    check("rst_stall", {31'b0, o_stall}, 32'd0);
    check("rst_req", {31'b0, o_bus_req}, 32'd0);
    check("rst_we", {31'b0, o_bus_we}, 32'd0);
    check("rst_addr", o_bus_addr, 32'd0);
    check("rst_wdata", o_bus_wdata, 32'd0);
    check("rst_be", {28'b0, o_bus_be}, 32'd0);
    check("rst_load_data", o_load_data, 32'd0);
    check("rst_load_valid", {31'b0, o_load_valid}, 32'd0);
    idle_inputs();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Loads of each size and sign.
    mem_op(1'b1, 1'b0, F3W, 32'h100, 32'h0, 2, 32'hDEAD_BEEF,
           '{addr: 32'h100, we: 1'b0, wdata: 32'h0, be: 4'hF}, 1'b1, 32'hDEAD_BEEF);
    mem_op(1'b1, 1'b0, F3B, 32'h103, 32'h0, 1, 32'h8012_3456,
           '{addr: 32'h100, we: 1'b0, wdata: 32'h0, be: 4'hF}, 1'b1, 32'hFFFF_FF80);
    mem_op(1'b1, 1'b0, F3BU, 32'h103, 32'h0, 1, 32'h8012_3456,
           '{addr: 32'h100, we: 1'b0, wdata: 32'h0, be: 4'hF}, 1'b1, 32'h0000_0080);
    mem_op(1'b1, 1'b0, F3HU, 32'h102, 32'h0, 1, 32'h8012_3456,
           '{addr: 32'h100, we: 1'b0, wdata: 32'h0, be: 4'hF}, 1'b1, 32'h0000_8012);
    mem_op(1'b1, 1'b0, F3H, 32'h102, 32'h0, 3, 32'h8012_3456,
           '{addr: 32'h100, we: 1'b0, wdata: 32'h0, be: 4'hF}, 1'b1, 32'hFFFF_8012);
    mem_op(1'b1, 1'b0, F3H, 32'h100, 32'h0, 1, 32'h8012_3456,
           '{addr: 32'h100, we: 1'b0, wdata: 32'h0, be: 4'hF}, 1'b1, 32'h0000_3456);

    // Stores: halfword upper, byte lane 1; no load result expected.
    mem_op(1'b0, 1'b1, F3H, 32'h202, 32'h0000_ABCD, 1, 32'h0,
           '{addr: 32'h200, we: 1'b1, wdata: 32'hABCD_ABCD, be: 4'b1100}, 1'b0, 32'h0);
    mem_op(1'b0, 1'b1, F3B, 32'h201, 32'h1234_5677, 2, 32'h0,
           '{addr: 32'h200, we: 1'b1, wdata: 32'h7777_7777, be: 4'b0010}, 1'b0, 32'h0);

    // Misaligned accesses never request or stall.
    misaligned_op(1'b1, 1'b0, F3W, 32'h102);
    misaligned_op(1'b1, 1'b0, F3H, 32'h101);
    misaligned_op(1'b0, 1'b1, F3W, 32'h201);

    // Reset during WAIT, then a late ack.
    bus_q.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0, be: 4'hF});
    drive(1'b1, 1'b0, F3W, 32'h300, 32'h0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("rstwait_req_before", {31'b0, o_bus_req}, 32'd1);
    #2;
    i_rst = 1'b1;
    idle_inputs();
    #1;
    check("rstwait_req", {31'b0, o_bus_req}, 32'd0);
    check("rstwait_stall", {31'b0, o_stall}, 32'd0);
    check("rstwait_load_data", o_load_data, 32'd0);
    check("rstwait_load_valid", {31'b0, o_load_valid}, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_bus_ack = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
    @(negedge i_clk);
    check("late_ack_req", {31'b0, o_bus_req}, 32'd0);
    check("late_ack_stall", {31'b0, o_stall}, 32'd0);
    @(posedge i_clk); #1;
    i_bus_ack = 1'b0; i_bus_rdata = '0;
    @(negedge i_clk);
    check("late_ack_load_valid", {31'b0, o_load_valid}, 32'd0);
    check("late_ack_load_data", o_load_data, 32'd0);
    @(posedge i_clk); #1;

    // Back-to-back store then load, immediate acks: stall 1,1,0,1,1,0.
    mem_op(1'b0, 1'b1, F3W, 32'h10, 32'hCAFE_F00D, 1, 32'h0,
           '{addr: 32'h10, we: 1'b1, wdata: 32'hCAFE_F00D, be: 4'hF}, 1'b0, 32'h0);
    mem_op(1'b1, 1'b0, F3W, 32'h14, 32'h0, 1, 32'h0123_4567,
           '{addr: 32'h14, we: 1'b0, wdata: 32'h0, be: 4'hF}, 1'b1, 32'h0123_4567);

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("bus_queue_drained", bus_q.size(), 32'd0);
    check("load_queue_drained", load_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
